// File: rtl/main_memory_ctrl.sv
// ============================================================================
// main_memory_ctrl : fixed-latency word store servicing the L1 data cache.
// Optional MAIN_MEMORY_STATS_EN adds read_count / write_count outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module main_memory_ctrl #(
   parameter int MEM_WORDS     = 4096,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_write_value,
   output logic [31:0] mem_read_value,
   output logic        mem_valid,
   output logic        busy
`ifdef MAIN_MEMORY_STATS_EN
  ,output logic [31:0] read_count
  ,output logic [31:0] write_count
`endif
);

   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   logic [31:0]      mem_q [MEM_WORDS];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      data_q, data_d;
   logic             wr_op_q, wr_op_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             wr_commit;
`ifdef MAIN_MEMORY_STATS_EN
   logic [31:0]      rd_cnt_q, rd_cnt_d;
   logic [31:0]      wr_cnt_q, wr_cnt_d;
`endif

   logic w_unused_addr;
   assign w_unused_addr = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      wr_op_d   = wr_op_q;
      rdata_d   = rdata_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      wr_commit = 1'b0;
`ifdef MAIN_MEMORY_STATS_EN
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_read_enable | mem_write_enable) begin
               idx_d   = mem_address[IDX_W+1:2];
               data_d  = mem_write_value;
               wr_op_d = mem_write_enable;
               cnt_d   = mem_write_enable ? W_LOAD : R_LOAD;
               busy_d  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Counter reaching zero marks the completion edge, LAT edges after acceptance.
            if (cnt_q == '0) begin
               state_d = RESP;
               valid_d = 1'b1;
               if (wr_op_q) begin
                  wr_commit = 1'b1;
`ifdef MAIN_MEMORY_STATS_EN
                  wr_cnt_d  = wr_cnt_q + 32'd1;
`endif
               end else begin
                  rdata_d = mem_q[idx_q];
`ifdef MAIN_MEMORY_STATS_EN
                  rd_cnt_d = rd_cnt_q + 32'd1;
`endif
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         wr_op_q  <= 1'b0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef MAIN_MEMORY_STATS_EN
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         wr_op_q  <= wr_op_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef MAIN_MEMORY_STATS_EN
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
`endif
      end
   end

   // Array is never cleared; a reset on the completion edge still blocks the commit.
   always_ff @(posedge clk) begin
      if (!reset && wr_commit) begin
         mem_q[idx_q] <= data_q;
      end
   end

   assign mem_read_value = rdata_q;
   assign mem_valid      = valid_q;
   assign busy           = busy_q;
`ifdef MAIN_MEMORY_STATS_EN
   assign read_count     = rd_cnt_q;
   assign write_count    = wr_cnt_q;
`endif

endmodule

`default_nettype wire
